// File: rtl/ir_packet_sequencer_if.sv
// Trigger/command inputs and LED/status outputs of the IR packet sequencer.
// The sequencer takes the slave side; the trigger source and LED pin logic take the master side.
interface ir_packet_sequencer_if;
    logic       SEND_PACKET;
    logic       ENABLE;
    logic [3:0] COMMAND;
    logic       IR_LED;
    logic       BUSY;
    logic       PKT_DONE;

    modport master (
        output SEND_PACKET,
        output ENABLE,
        output COMMAND,
        input  IR_LED,
        input  BUSY,
        input  PKT_DONE
    );

    modport slave (
        input  SEND_PACKET,
        input  ENABLE,
        input  COMMAND,
        output IR_LED,
        output BUSY,
        output PKT_DONE
    );
endinterface

// File: rtl/ir_packet_sequencer.sv
// Sends one IR packet (Start, CarSelect, Right, Left, Backward, Forward bursts separated by gaps) per SEND_PACKET rise.
// IR_LED rises on the edge that accepts the trigger; triggers arriving while BUSY are dropped, never queued.
module ir_packet_sequencer #(
    parameter int CARRIER_HALF   = 1389,
    parameter int START_BURST    = 191,
    parameter int CARSEL_BURST   = 47,
    parameter int GAP_SIZE       = 25,
    parameter int ASSERT_BURST   = 47,
    parameter int DEASSERT_BURST = 22,
    parameter int CNT_WIDTH      = 11,
    parameter int BURST_WIDTH    = 8
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    ir_packet_sequencer_if.slave   bus
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] GAP    = 3'd2;
    localparam logic [2:0] CARSEL = 3'd3;
    localparam logic [2:0] RIGHT  = 3'd4;
    localparam logic [2:0] LEFT   = 3'd5;
    localparam logic [2:0] BACK   = 3'd6;
    localparam logic [2:0] FWD    = 3'd7;

    localparam logic [CNT_WIDTH-1:0]   HALF_LAST     = CNT_WIDTH'(CARRIER_HALF - 1);
    localparam logic [BURST_WIDTH-1:0] START_LAST    = BURST_WIDTH'(START_BURST - 1);
    localparam logic [BURST_WIDTH-1:0] CARSEL_LAST   = BURST_WIDTH'(CARSEL_BURST - 1);
    localparam logic [BURST_WIDTH-1:0] GAP_LAST      = BURST_WIDTH'(GAP_SIZE - 1);
    localparam logic [BURST_WIDTH-1:0] ASSERT_LAST   = BURST_WIDTH'(ASSERT_BURST - 1);
    localparam logic [BURST_WIDTH-1:0] DEASSERT_LAST = BURST_WIDTH'(DEASSERT_BURST - 1);

    logic [2:0]             state;
    logic [2:0]             next_seg;
    logic [CNT_WIDTH-1:0]   half_cnt;
    logic                   phase_low;
    logic [BURST_WIDTH-1:0] burst_cnt;
    logic [3:0]             cmd_q;
    logic                   send_q;
    logic                   ir_led;
    logic                   busy;
    logic                   pkt_done;

    logic [BURST_WIDTH-1:0] seg_last;
    logic [2:0]             follow;
    logic                   half_end;
    logic                   period_end;
    logic                   seg_end;
    logic                   trigger;

    // Carrier periods minus one for the segment in progress; direction bursts follow the latched command.
    always_comb begin
        seg_last = '0;
        case (state)
            START:   seg_last = START_LAST;
            GAP:     seg_last = GAP_LAST;
            CARSEL:  seg_last = CARSEL_LAST;
            RIGHT:   seg_last = cmd_q[0] ? ASSERT_LAST : DEASSERT_LAST;
            LEFT:    seg_last = cmd_q[1] ? ASSERT_LAST : DEASSERT_LAST;
            BACK:    seg_last = cmd_q[2] ? ASSERT_LAST : DEASSERT_LAST;
            FWD:     seg_last = cmd_q[3] ? ASSERT_LAST : DEASSERT_LAST;
            default: seg_last = '0;
        endcase
    end

    always_comb begin
        follow = IDLE;
        case (state)
            START:   follow = CARSEL;
            CARSEL:  follow = RIGHT;
            RIGHT:   follow = LEFT;
            LEFT:    follow = BACK;
            BACK:    follow = FWD;
            default: follow = IDLE;
        endcase
    end

    assign half_end   = (half_cnt == HALF_LAST);
    assign period_end = half_end & phase_low;
    assign seg_end    = period_end & (burst_cnt == seg_last);
    assign trigger    = bus.SEND_PACKET & ~send_q & bus.ENABLE & (state == IDLE);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            next_seg  <= IDLE;
            half_cnt  <= '0;
            phase_low <= 1'b0;
            burst_cnt <= '0;
            cmd_q     <= 4'b0000;
            send_q    <= 1'b0;
            ir_led    <= 1'b0;
            busy      <= 1'b0;
            pkt_done  <= 1'b0;
        end else begin
            send_q   <= bus.SEND_PACKET;
            pkt_done <= 1'b0;
            if (state == IDLE) begin
                if (trigger) begin
                    cmd_q     <= bus.COMMAND;
                    state     <= START;
                    busy      <= 1'b1;
                    ir_led    <= 1'b1;
                    half_cnt  <= '0;
                    phase_low <= 1'b0;
                    burst_cnt <= '0;
                end
            end else begin
                half_cnt <= half_end ? '0 : half_cnt + 1'b1;
                if (half_end) begin
                    phase_low <= ~phase_low;
                end
                if (seg_end) begin
                    burst_cnt <= '0;
                    if (state == GAP) begin
                        state <= next_seg;
                        if (next_seg == IDLE) begin
                            busy     <= 1'b0;
                            pkt_done <= 1'b1;
                            ir_led   <= 1'b0;
                        end else begin
                            ir_led <= 1'b1;
                        end
                    end else begin
                        state    <= GAP;
                        next_seg <= follow;
                        ir_led   <= 1'b0;
                    end
                end else if (period_end) begin
                    // New carrier period: high again unless this is a gap.
                    burst_cnt <= burst_cnt + 1'b1;
                    ir_led    <= (state != GAP);
                end else if (half_end) begin
                    ir_led <= 1'b0;
                end
            end
        end
    end

    assign bus.IR_LED   = ir_led;
    assign bus.BUSY     = busy;
    assign bus.PKT_DONE = pkt_done;

endmodule

// File: tb/tb_ir_packet_sequencer.sv
// Bench for ir_packet_sequencer: random and directed packets compared against a segment-list waveform model.
module tb_ir_packet_sequencer;

    localparam int CH     = 2;
    localparam int START  = 4;
    localparam int CARSEL = 3;
    localparam int GAP    = 2;
    localparam int ASSERT = 3;
    localparam int DEASRT = 1;
    localparam int WIN    = 160;

    logic CLK = 1'b0;
    logic RESET_N;
    int   compared   = 0;
    int   mismatched = 0;

    ir_packet_sequencer_if bus ();

    ir_packet_sequencer #(
        .CARRIER_HALF   (CH),
        .START_BURST    (START),
        .CARSEL_BURST   (CARSEL),
        .GAP_SIZE       (GAP),
        .ASSERT_BURST   (ASSERT),
        .DEASSERT_BURST (DEASRT),
        .CNT_WIDTH      (11),
        .BURST_WIDTH    (8)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference waveform: packet as a list of (periods, carrier-on) segments, expanded sample by sample.
    task automatic build_wave(input logic [3:0] c, output logic [255:0] w, output int len);
        int n[12];
        bit on[12];
        n[0] = START;  on[0] = 1;
        n[1] = GAP;    on[1] = 0;
        n[2] = CARSEL; on[2] = 1;
        n[3] = GAP;    on[3] = 0;
        for (int d = 0; d < 4; d++) begin
            n[4 + 2*d] = c[d] ? ASSERT : DEASRT; on[4 + 2*d] = 1;
            n[5 + 2*d] = GAP;                    on[5 + 2*d] = 0;
        end
        w = '0;
        len = 0;
        for (int s = 0; s < 12; s++)
            for (int p = 0; p < n[s]; p++)
                for (int h = 0; h < 2*CH; h++) begin
                    w[len] = on[s] && (h < CH);
                    len++;
                end
    endtask

    // Called just after a negedge with SEND_PACKET low for at least one edge.
    task automatic run_packet(input string tag, input logic [3:0] cmd, input bit en,
                              input int chg_at, input logic [3:0] chg_cmd,
                              input bit retrig, input int en_drop_at);
        logic [255:0] exp_led, exp_busy, exp_done;
        logic [255:0] obs_led, obs_busy, obs_done;
        int len;
        build_wave(cmd, exp_led, len);
        exp_busy = '0;
        exp_done = '0;
        if (en) begin
            for (int k = 0; k < len; k++) exp_busy[k] = 1'b1;
            exp_done[len] = 1'b1;
        end else begin
            exp_led = '0;
        end
        obs_led = '0; obs_busy = '0; obs_done = '0;
        bus.COMMAND     = cmd;
        bus.ENABLE      = en;
        bus.SEND_PACKET = 1'b1;
        for (int k = 0; k < WIN; k++) begin
            @(negedge CLK);
            obs_led[k]  = bus.IR_LED;
            obs_busy[k] = bus.BUSY;
            obs_done[k] = bus.PKT_DONE;
            if (k == chg_at) bus.COMMAND = chg_cmd;
            if (k == en_drop_at) bus.ENABLE = 1'b0;
            if (retrig) begin
                if (k == 5 || k == 45) bus.SEND_PACKET = 1'b0;
                if (k == 39 || k == len - 1) bus.SEND_PACKET = 1'b1;
            end
        end
        check({tag, " led"},  obs_led,  exp_led);
        check({tag, " busy"}, obs_busy, exp_busy);
        check({tag, " done"}, obs_done, exp_done);
        bus.SEND_PACKET = 1'b0;
        bus.ENABLE      = 1'b1;
        repeat (2 + $urandom_range(0, 3)) @(negedge CLK);
    endtask

    initial begin
        logic [255:0] w;
        int len;
        RESET_N         = 1'b0;
        bus.SEND_PACKET = 1'b0;
        bus.ENABLE      = 1'b1;
        bus.COMMAND     = 4'b0000;
        repeat (3) @(negedge CLK);
        check("reset led",  bus.IR_LED,   1'b0);
        check("reset busy", bus.BUSY,     1'b0);
        check("reset done", bus.PKT_DONE, 1'b0);
        RESET_N = 1'b1;
        repeat (2) @(negedge CLK);

        run_packet("cmd0000", 4'b0000, 1'b1, -1, 4'b0000, 1'b0, -1);
        run_packet("cmd1111", 4'b1111, 1'b1, -1, 4'b0000, 1'b0, -1);
        run_packet("cmd0101 chg", 4'b0101, 1'b1, 20, 4'b1010, 1'b0, -1);
        run_packet("retrig", 4'b0011, 1'b1, -1, 4'b0000, 1'b1, -1);
        run_packet("disabled", 4'b1001, 1'b0, -1, 4'b0000, 1'b0, -1);
        run_packet("en drop", 4'b0110, 1'b1, -1, 4'b0000, 1'b0, 30);

        for (int i = 0; i < 8; i++) begin
            logic [3:0] c, c2;
            c  = 4'($urandom);
            c2 = 4'($urandom);
            run_packet($sformatf("rand%0d", i), c, 1'b1, int'($urandom_range(0, 100)), c2,
                       1'($urandom), ($urandom % 2) ? int'($urandom_range(1, 80)) : -1);
        end

        // Asynchronous reset between clock edges in the middle of a packet.
        build_wave(4'b0000, w, len);
        bus.COMMAND     = 4'b0000;
        bus.SEND_PACKET = 1'b1;
        for (int k = 0; k < 30; k++) @(negedge CLK);
        check("pre-reset led",  bus.IR_LED, w[29]);
        check("pre-reset busy", bus.BUSY,   1'b1);
        #2 RESET_N = 1'b0;
        #1;
        check("async reset led",  bus.IR_LED,   1'b0);
        check("async reset busy", bus.BUSY,     1'b0);
        check("async reset done", bus.PKT_DONE, 1'b0);
        @(negedge CLK);
        bus.SEND_PACKET = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1;
        repeat (2) @(negedge CLK);
        run_packet("post-reset", 4'b0000, 1'b1, -1, 4'b0000, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ir_packet_sequencer.md
Name: ir_packet_sequencer

Overview:
- Sequences one IR remote-control packet each time the 10 Hz send trigger rises.
- A packet is a fixed-order series of carrier bursts and gaps: Start, CarSelect, Right, Left, Backward, Forward.
- Generates the gated carrier and drives the IR LED; reports busy/done to the top level.
- Sits between the 10 Hz trigger counter (SEND_PACKET source) and the IR LED pin; the command bits come from the button/mouse decode logic.

Parameters:
CARRIER_HALF, 1389, clocks per carrier half-period (100 MHz / 36 kHz / 2)
START_BURST, 191, Start burst length in carrier periods
CARSEL_BURST, 47, CarSelect burst length in carrier periods
GAP_SIZE, 25, gap length in carrier periods (IR_LED held low)
ASSERT_BURST, 47, direction burst length when the command bit is 1
DEASSERT_BURST, 22, direction burst length when the command bit is 0
CNT_WIDTH, 11, width of the half-period counter; 2^CNT_WIDTH must exceed CARRIER_HALF
BURST_WIDTH, 8, width of the burst counter; 2^BURST_WIDTH must exceed the largest burst/gap value

Ports:
CLK  in  1  system clock, 100 MHz
RESET_N  in  1  asynchronous, active-low reset
SEND_PACKET  in  1  trigger level, synchronous to CLK; a rising edge requests one packet
ENABLE  in  1  when 1, triggers are accepted; when 0, triggers are ignored
COMMAND  in  4  {FORWARD, BACKWARD, LEFT, RIGHT} bits, sampled when a trigger is accepted
IR_LED  out  1  modulated carrier output
BUSY  out  1  high while a packet is in progress
PKT_DONE  out  1  one-cycle pulse at packet completion

Behaviour:
- Reset (RESET_N=0, asynchronous):
  - FSM goes to IDLE.
  - IR_LED=0, BUSY=0, PKT_DONE=0.
  - All counters are cleared; the SEND_PACKET edge register is cleared to 0; the latched command is cleared to 0.
  - Reset mid-packet forces IR_LED low immediately, with no clock required.
- Trigger:
  - send_q is a registered copy of SEND_PACKET.
  - A rising edge is detected when SEND_PACKET=1 and send_q=0 at a clock edge.
  - The trigger is accepted only in IDLE with ENABLE=1.
  - On acceptance, at that same edge: COMMAND is latched, FSM enters START, BUSY=1, IR_LED=1.
  - Latency: IR_LED rises at the first clock edge that samples SEND_PACKET high.
- FSM order: IDLE -> START -> GAP -> CARSEL -> GAP -> RIGHT -> GAP -> LEFT -> GAP -> BACK -> GAP -> FWD -> GAP -> IDLE.
  - A next-segment register selects which burst follows each GAP.
- Burst segment of N carrier periods:
  - IR_LED is high for CARRIER_HALF clocks, then low for CARRIER_HALF clocks, repeated N times.
  - Total burst length is exactly 2*N*CARRIER_HALF clocks.
  - The carrier phase restarts high at the start of every burst.
- Gap segment: IR_LED=0 for 2*GAP_SIZE*CARRIER_HALF clocks.
- Direction burst length: ASSERT_BURST if the latched bit is 1, otherwise DEASSERT_BURST.
  - RIGHT uses COMMAND[0], LEFT uses [1], BACK uses [2], FWD uses [3].
- Counters:
  - The half-period counter wraps at CARRIER_HALF-1.
  - The burst counter increments at the end of each full carrier period.
  - The segment ends when burst count == N-1 and the period completes; no off-by-one is allowed.
- Completion:
  - At the edge that ends the final GAP: FSM returns to IDLE, BUSY=0, PKT_DONE=1 for exactly one cycle.
- Triggers while BUSY=1 are dropped, not queued; this includes a rising edge on the completion edge.
- COMMAND changes during a packet have no effect on that packet.
- ENABLE falling mid-packet does not abort the packet; it blocks only subsequent triggers.
- SEND_PACKET held high produces one packet only; a new low->high transition is required.

Test Plan:
(Bench parameters: CARRIER_HALF=2, START=4, CARSEL=3, GAP=2, ASSERT=3, DEASSERT=1.)
1. Reset, then SEND_PACKET rises with COMMAND=0000, ENABLE=1 -> IR_LED pattern 1100 repeated 4 times; 8 low clocks; 1100 x3; then gaps and 1-period bursts; BUSY high exactly 92 clocks; one PKT_DONE pulse.
2. COMMAND=1111 -> packet is 124 clocks; each direction burst has 3 carrier periods (12 clocks).
3. COMMAND=0101 latched, then COMMAND changed to 1010 mid-packet -> RIGHT and BACK have 12-clock bursts, LEFT and FWD have 4-clock bursts; total 108 clocks.
4. Second SEND_PACKET rising edge at clock 40 of a packet, and another on the PKT_DONE edge -> both ignored; only one PKT_DONE; IR_LED stays 0 afterwards.
5. ENABLE=0 with a trigger -> IR_LED and BUSY stay 0. ENABLE dropped mid-packet -> the packet completes normally.
6. RESET_N asserted low at clock 30 of a packet, between clock edges -> IR_LED, BUSY, PKT_DONE go to 0 asynchronously. After release, a new trigger produces a full 92-clock packet.
